// File: rtl/pipeline_hazard_unit_if.sv
// Bundle of decode/forwarding/control signals between the pipeline and the hazard unit.
// The pipeline side drives the request fields; the hazard unit drives operands, stall/flush and statistics.
interface pipeline_hazard_unit_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD        = 3,
  parameter int CNT_WIDTH      = 16
);
  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_addr;
  logic [NUM_SRC-1:0]                src_used;
  logic [NUM_SRC*DATA_WIDTH-1:0]     src_data;
  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_addr;
  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data;
  logic [NUM_FWD-1:0]                fwd_valid;
  logic [NUM_FWD-1:0]                fwd_is_load;
  logic                              pc_chg;
  logic                              stats_clr;
  logic [NUM_SRC*DATA_WIDTH-1:0]     op_data;
  logic                              stall;
  logic                              flush;
  logic [CNT_WIDTH-1:0]              stall_cnt;
  logic [CNT_WIDTH-1:0]              flush_cnt;

  modport master (
    output src_addr, src_used, src_data, fwd_addr, fwd_data, fwd_valid, fwd_is_load,
           pc_chg, stats_clr,
    input  op_data, stall, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  src_addr, src_used, src_data, fwd_addr, fwd_data, fwd_valid, fwd_is_load,
           pc_chg, stats_clr,
    output op_data, stall, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Decode/execute hazard control: operand forwarding, multi-cycle load-use stall,
// branch flush sequencing and saturating stall/flush statistics.
module pipeline_hazard_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD        = 3,
  parameter int LOAD_LAT       = 1,
  parameter int FLUSH_CYCLES   = 2,
  parameter int ZERO_REG_EN    = 1,
  parameter int CNT_WIDTH      = 16
) (
  input logic                   clk,
  input logic                   RST,
  pipeline_hazard_unit_if.slave bus
);

  localparam int SCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [SCW-1:0] SC_INIT = SCW'(LOAD_LAT - 1);
  localparam logic [FCW-1:0] FC_INIT = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

  state_t                         state_q, state_d;
  logic [SCW-1:0]                 scnt_q, scnt_d;
  logic [FCW-1:0]                 fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0]           stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]           flush_cnt_q, flush_cnt_d;
  logic [NUM_SRC-1:0][NUM_FWD-1:0] match;
  logic [NUM_SRC*DATA_WIDTH-1:0]  op_data_c;
  logic                           hz;
  logic                           found;
  logic                           stall_c, flush_c;
  logic                           stall_o, flush_o;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < NUM_FWD; k++) begin
        match[i][k] = bus.fwd_valid[k] && bus.src_used[i] &&
                      (bus.fwd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] ==
                       bus.src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) &&
                      !((ZERO_REG_EN != 0) &&
                        (bus.src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == '0));
      end
    end
  end

  // Youngest matching stage wins; if it is a pending load, the port keeps the
  // register-file value and the stall covers the hazard.
  always_comb begin
    op_data_c = bus.src_data;
    hz        = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      found = 1'b0;
      for (int k = 0; k < NUM_FWD; k++) begin
        if (match[i][k] && bus.fwd_is_load[k]) hz = 1'b1;
        if (match[i][k] && !found) begin
          found = 1'b1;
          if (!bus.fwd_is_load[k])
            op_data_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.fwd_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    fcnt_d  = fcnt_q;
    stall_c = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pc_chg) begin
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FC_INIT;
          end
        end else if (hz) begin
          stall_c = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            scnt_d  = SC_INIT;
          end
        end
      end
      STALL: begin
        if (bus.pc_chg) begin
          flush_c = 1'b1;
          scnt_d  = '0;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FC_INIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          stall_c = 1'b1;
          if (scnt_q <= SCW'(1)) begin
            state_d = IDLE;
            scnt_d  = '0;
          end else begin
            scnt_d = scnt_q - SCW'(1);
          end
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (bus.pc_chg) begin
          fcnt_d = FC_INIT;
        end else if (fcnt_q <= FCW'(1)) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controls are gated by reset so nothing leaks out while RST is low.
  assign stall_o = stall_c & RST;
  assign flush_o = flush_c & RST;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.stats_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_o)    stall_cnt_d = sat_inc(stall_cnt_q);
      if (bus.pc_chg) flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      scnt_q      <= '0;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.op_data   = op_data_c;
  assign bus.stall     = stall_o;
  assign bus.flush     = flush_o;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: forwarding priority, zero register,
// load-use stall length, branch abort/flush, reset during flush and counter saturation.
module tb_pipeline_hazard_unit;

  logic clk;
  logic RST;
  int   errors;
  int   checks;

  pipeline_hazard_unit_if #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4), .NUM_SRC(2),
                            .NUM_FWD(3), .CNT_WIDTH(3)) b0 ();
  pipeline_hazard_unit_if #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4), .NUM_SRC(2),
                            .NUM_FWD(3), .CNT_WIDTH(3)) b1 ();

  pipeline_hazard_unit #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4), .NUM_SRC(2), .NUM_FWD(3),
                         .LOAD_LAT(3), .FLUSH_CYCLES(2), .ZERO_REG_EN(1), .CNT_WIDTH(3))
    u0 (.clk(clk), .RST(RST), .bus(b0.slave));

  pipeline_hazard_unit #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4), .NUM_SRC(2), .NUM_FWD(3),
                         .LOAD_LAT(1), .FLUSH_CYCLES(2), .ZERO_REG_EN(0), .CNT_WIDTH(3))
    u1 (.clk(clk), .RST(RST), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    RST = 1'b0;
    b0.src_addr = '0; b0.src_used = '0; b0.src_data = '0;
    b0.fwd_addr = '0; b0.fwd_data = '0; b0.fwd_valid = '0; b0.fwd_is_load = '0;
    b0.pc_chg = 1'b0; b0.stats_clr = 1'b0;
    b1.src_addr = '0; b1.src_used = '0; b1.src_data = '0;
    b1.fwd_addr = '0; b1.fwd_data = '0; b1.fwd_valid = '0; b1.fwd_is_load = '0;
    b1.pc_chg = 1'b0; b1.stats_clr = 1'b0;

    // Reset: branch and load hazard both present, controls must stay low
    b0.src_data = {16'h00B0, 16'h00A0};
    b0.pc_chg = 1'b1;
    b0.fwd_addr[3:0] = 4'd5; b0.fwd_valid[0] = 1'b1; b0.fwd_is_load[0] = 1'b1;
    b0.src_addr[3:0] = 4'd5; b0.src_used[0] = 1'b1;
    #2;
    chk("rst_stall", 32'(b0.stall), 32'd0);
    chk("rst_flush", 32'(b0.flush), 32'd0);
    chk("rst_stall_cnt", 32'(b0.stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(b0.flush_cnt), 32'd0);
    chk("rst_op_data", b0.op_data, 32'h00B0_00A0);
    tick();
    b0.pc_chg = 1'b0; b0.fwd_valid = '0; b0.fwd_is_load = '0; b0.src_used = '0;
    tick();
    RST = 1'b1;
    tick();

    // Youngest non-load match forwards
    b0.fwd_addr[3:0] = 4'd3; b0.fwd_data[15:0] = 16'h1111; b0.fwd_valid[0] = 1'b1;
    b0.fwd_addr[7:4] = 4'd3; b0.fwd_data[31:16] = 16'h2222; b0.fwd_valid[1] = 1'b1;
    b0.src_addr[3:0] = 4'd3; b0.src_addr[7:4] = 4'd7; b0.src_used = 2'b11;
    #1;
    chk("fwd_young_op0", 32'(b0.op_data[15:0]), 32'h1111);
    chk("fwd_nomatch_op1", 32'(b0.op_data[31:16]), 32'h00B0);
    chk("fwd_young_stall", 32'(b0.stall), 32'd0);
    b0.fwd_valid[0] = 1'b0;
    #1;
    chk("fwd_older_op0", 32'(b0.op_data[15:0]), 32'h2222);
    b0.fwd_valid[0] = 1'b1; b0.fwd_is_load[0] = 1'b1;
    #1;
    chk("load_block_op0", 32'(b0.op_data[15:0]), 32'h00A0);
    chk("load_block_stall", 32'(b0.stall), 32'd1);
    b0.fwd_is_load[0] = 1'b0; b0.fwd_valid = '0;
    #1;

    // Register 0 with and without the hardwired-zero option
    b0.src_used = 2'b10; b0.src_addr[7:4] = 4'd0;
    b0.fwd_addr[3:0] = 4'd0; b0.fwd_data[15:0] = 16'hBEEF; b0.fwd_valid[0] = 1'b1;
    b1.src_data = {16'h00B0, 16'h00A0}; b1.src_used = 2'b10; b1.src_addr = '0;
    b1.fwd_addr = '0; b1.fwd_data[15:0] = 16'hBEEF; b1.fwd_valid[0] = 1'b1;
    #1;
    chk("zero_reg_en1_op1", 32'(b0.op_data[31:16]), 32'h00B0);
    chk("zero_reg_en0_op1", 32'(b1.op_data[31:16]), 32'hBEEF);
    b0.fwd_valid = '0; b1.fwd_valid = '0;

    // Load to r5 not actually read by the instruction
    b0.fwd_addr[3:0] = 4'd5; b0.fwd_valid[0] = 1'b1; b0.fwd_is_load[0] = 1'b1;
    b0.src_addr[3:0] = 4'd5; b0.src_used = 2'b00;
    #1;
    chk("unused_src_stall", 32'(b0.stall), 32'd0);
    tick();
    chk("unused_src_stall_cnt", 32'(b0.stall_cnt), 32'd0);

    // Load-use: three stall cycles
    b0.src_used = 2'b01;
    #1;
    chk("lu_t0_stall", 32'(b0.stall), 32'd1);
    tick();
    chk("lu_t1_stall", 32'(b0.stall), 32'd1);
    chk("lu_t1_flush", 32'(b0.flush), 32'd0);
    b0.fwd_valid = '0;
    tick();
    chk("lu_t2_stall", 32'(b0.stall), 32'd1);
    tick();
    chk("lu_t3_stall", 32'(b0.stall), 32'd0);
    chk("lu_stall_cnt", 32'(b0.stall_cnt), 32'd3);

    // Branch resolves during the second stall cycle
    b0.fwd_valid[0] = 1'b1;
    #1;
    chk("ab_t0_stall", 32'(b0.stall), 32'd1);
    tick();
    b0.pc_chg = 1'b1; b0.fwd_valid = '0;
    #1;
    chk("ab_t1_stall", 32'(b0.stall), 32'd0);
    chk("ab_t1_flush", 32'(b0.flush), 32'd1);
    tick();
    b0.pc_chg = 1'b0;
    #1;
    chk("ab_t2_flush", 32'(b0.flush), 32'd1);
    chk("ab_t2_stall", 32'(b0.stall), 32'd0);
    tick();
    chk("ab_t3_flush", 32'(b0.flush), 32'd0);
    chk("ab_flush_cnt", 32'(b0.flush_cnt), 32'd1);
    chk("ab_stall_cnt", 32'(b0.stall_cnt), 32'd4);

    // Reset asserted while in FLUSH
    b0.pc_chg = 1'b1;
    tick();
    b0.pc_chg = 1'b0;
    #1;
    chk("rf_flush_before", 32'(b0.flush), 32'd1);
    RST = 1'b0;
    #1;
    chk("rf_flush_in_rst", 32'(b0.flush), 32'd0);
    tick();
    RST = 1'b1;
    #1;
    chk("rf_flush_after", 32'(b0.flush), 32'd0);
    chk("rf_stall_cnt", 32'(b0.stall_cnt), 32'd0);
    chk("rf_flush_cnt", 32'(b0.flush_cnt), 32'd0);
    tick();
    chk("rf_flush_next", 32'(b0.flush), 32'd0);

    // Continuous hazard drives the 3-bit stall counter into saturation
    b0.fwd_valid[0] = 1'b1; b0.fwd_is_load[0] = 1'b1;
    b0.src_addr[3:0] = 4'd5; b0.src_used = 2'b01;
    for (int n = 0; n < 8; n++) tick();
    chk("sat_stall", 32'(b0.stall), 32'd1);
    chk("sat_cnt", 32'(b0.stall_cnt), 32'd7);
    tick();
    chk("sat_hold_cnt", 32'(b0.stall_cnt), 32'd7);
    b0.stats_clr = 1'b1;
    tick();
    chk("clr_cnt", 32'(b0.stall_cnt), 32'd0);
    b0.stats_clr = 1'b0;
    tick();
    chk("post_clr_cnt", 32'(b0.stall_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
